lzc_part_select: RTL and testbench
==================================

LZC_PART_SELECT -- requirements
Module: lzc_part_select

Interface
REQ-001 Parameter WIDTH, default 32, input vector width (>=2).
REQ-002 Parameter ADD_OFFSET, default 1, constant added to the leading-zero count (0 or 1).
REQ-003 Parameter OUT_WIDTH, default 23, selected output field width (1..WIDTH).
REQ-004 Derived constant CNT_BITS = clog2(WIDTH+ADD_OFFSET+1).
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  qualifies in_data for this cycle.
REQ-008 in_data  in  WIDTH  value to normalize.
REQ-009 out_valid  out  1  registered in_valid.
REQ-010 out_count  out  CNT_BITS  leading zeros of in_data plus ADD_OFFSET.
REQ-011 out_frac  out  OUT_WIDTH  top OUT_WIDTH bits of the normalized, shifted value.
REQ-012 out_zero  out  1  high when in_data was all zeros.

Function
REQ-013 Count = number of leading zero bits of in_data counted from bit WIDTH-1, plus ADD_OFFSET.
REQ-014 All-zero input gives count = WIDTH+ADD_OFFSET and out_zero=1; otherwise out_zero=0.
REQ-015 Shifted = (in_data << count) truncated to WIDTH bits; a shift >= WIDTH gives 0.
REQ-016 With ADD_OFFSET=1, the leading one is shifted out (hidden-bit removal); with ADD_OFFSET=0 it lands at bit WIDTH-1.
REQ-017 out_frac = Shifted[WIDTH-1 -: OUT_WIDTH], the MSB-aligned part select.
REQ-018 Latency is exactly 1 cycle: outputs reflect the in_data/in_valid sampled at the previous rising edge.
REQ-019 There is no backpressure; a new input is accepted every cycle.
REQ-020 Data outputs load on every edge regardless of in_valid; consumers qualify them with out_valid.
REQ-021 The datapath is purely combinational between the input and the single output register stage.

Reset
REQ-022 While reset is high, outputs are held at: out_valid=0, out_count=0, out_frac=0, out_zero=0.
REQ-023 Reset asserts immediately, without waiting for a clock edge.
REQ-024 Reset asserted mid-stream discards the in-flight result.
REQ-025 The first valid output after reset deassertion appears 1 cycle after the first sampled in_valid=1.

Structure
REQ-026 Shared package lzc_pkg holds a function computing CNT_BITS from WIDTH and ADD_OFFSET, for reuse by instantiators.
REQ-027 Leading-zero counting lives in one sub-module lzc_tree, a combinational log-depth priority tree parameterized by WIDTH and ADD_OFFSET.
REQ-028 The shifter, part select and output register reside in lzc_part_select.

Verification (WIDTH=8, ADD_OFFSET=1, OUT_WIDTH=4)
REQ-029 in_data=0x80 -> next cycle count=1, frac=0x0, zero=0.
REQ-030 in_data=0x2C -> count=3, frac=0x6, zero=0.
REQ-031 in_data=0x00 -> count=9, frac=0x0, zero=1; in_data=0x01 -> count=8, frac=0x0, zero=0.
REQ-032 in_data=0xFF -> count=1, frac=0xF; back-to-back 0xFF, 0x2C, 0x00 on consecutive cycles -> results in the same order, one per cycle.
REQ-033 Reset pulsed between edges while out_valid=1 -> all outputs read 0 immediately, and stay 0 until a new in_valid is sampled.
REQ-034 Sweep all 256 inputs, including with ADD_OFFSET=0 -> count and frac match a software model.

Source files
------------

// File: rtl/lzc_pkg.sv
// Shared helpers for the leading-zero-count / normalize datapath.
package lzc_pkg;

  // Width of a count able to hold every value 0 .. width+add_offset.
  function automatic int cnt_bits(input int width, input int add_offset);
    return $clog2(width + add_offset + 1);
  endfunction

endpackage

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter built as a log-depth priority tree.
// The input is padded on the LSB side with ones up to a power of two so the
// padding never contributes leading zeros; an all-zero input is detected
// separately and reported as WIDTH leading zeros.
module lzc_tree
  import lzc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADD_OFFSET = 1,
  localparam int CNT_BITS  = cnt_bits(WIDTH, ADD_OFFSET)
) (
  input  logic [WIDTH-1:0]    data,
  output logic [CNT_BITS-1:0] count,
  output logic                zero
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int P      = 1 << LEVELS;
  localparam int CW     = LEVELS + 1;
  localparam int NODES  = 2 * P - 1;

  logic [P-1:0]    padded;
  // Heap layout: node k has children 2k+1 (upper half) and 2k+2 (lower half).
  logic            node_v   [NODES];
  logic [CW-1:0]   node_cnt [NODES];
  logic [31:0]     lz_ext;

  generate
    if (P == WIDTH) begin : g_nopad
      assign padded = data;
    end else begin : g_pad
      assign padded = {data, {(P - WIDTH){1'b1}}};
    end

    // Leaves: leaf j holds bit P-1-j, i.e. leaf 0 is the MSB.
    for (genvar j = 0; j < P; j++) begin : g_leaf
      assign node_v[P-1+j]   = padded[P-1-j];
      assign node_cnt[P-1+j] = '0;
    end

    // Internal nodes: prefer the upper half; otherwise skip it entirely.
    for (genvar d = 0; d < LEVELS; d++) begin : g_lvl
      for (genvar j = 0; j < (1 << d); j++) begin : g_node
        localparam int K = (1 << d) - 1 + j;
        localparam logic [CW-1:0] HALF = CW'(P >> (d + 1));
        assign node_v[K]   = node_v[2*K+1] | node_v[2*K+2];
        assign node_cnt[K] = node_v[2*K+1] ? node_cnt[2*K+1]
                                           : node_cnt[2*K+2] + HALF;
      end
    end
  endgenerate

  assign zero   = ~|data;
  assign lz_ext = zero ? 32'(WIDTH) : 32'(node_cnt[0]);
  assign count  = CNT_BITS'(lz_ext + 32'(ADD_OFFSET));

endmodule

// File: rtl/lzc_part_select.sv
// Normalizer: counts leading zeros (plus offset), shifts the input left by
// that count and registers the MSB-aligned field, with one cycle latency.
//
// Handshake: in_valid qualifies in_data in the cycle it is high; there is no
// ready, every cycle is accepted. out_valid is in_valid delayed one cycle and
// is the only qualifier for out_count/out_frac/out_zero, which load on every
// edge whether or not in_valid was high.
module lzc_part_select
  import lzc_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADD_OFFSET = 1,
  parameter int OUT_WIDTH  = 23,
  localparam int CNT_BITS  = cnt_bits(WIDTH, ADD_OFFSET)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  output logic [CNT_BITS-1:0]  out_count,
  output logic [OUT_WIDTH-1:0] out_frac,
  output logic                 out_zero
);

  logic [CNT_BITS-1:0]  lz_count;
  logic                 lz_zero;
  logic [WIDTH-1:0]     shifted;
  logic [OUT_WIDTH-1:0] frac_next;

  lzc_tree #(
    .WIDTH      (WIDTH),
    .ADD_OFFSET (ADD_OFFSET)
  ) u_tree (
    .data  (in_data),
    .count (lz_count),
    .zero  (lz_zero)
  );

  // Normalizing shift; a count reaching WIDTH clears the whole word.
  always_comb begin
    shifted = '0;
    if (32'(lz_count) < 32'(WIDTH)) begin
      shifted = in_data << lz_count;
    end
    frac_next = shifted[WIDTH-1 -: OUT_WIDTH];
  end

  // Single output register stage; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_frac  <= '0;
      out_zero  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      out_count <= lz_count;
      out_frac  <= frac_next;
      out_zero  <= lz_zero;
    end
  end

endmodule

// File: tb/tb_lzc_part_select.sv
// Bench for lzc_part_select at WIDTH=8, OUT_WIDTH=4, with one instance per
// ADD_OFFSET value (1 and 0) sharing the same inputs.
module tb_lzc_part_select;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;

  logic       v1, z1, v0, z0;
  logic [3:0] c1, f1, c0, f0;

  int total = 0;
  int bad   = 0;

  // {valid, zero, count1, frac1, count0, frac0}
  logic [17:0] exp_q[$];

  lzc_part_select #(.WIDTH(8), .ADD_OFFSET(1), .OUT_WIDTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (v1),
    .out_count (c1),
    .out_frac  (f1),
    .out_zero  (z1)
  );

  lzc_part_select #(.WIDTH(8), .ADD_OFFSET(0), .OUT_WIDTH(4)) dut0 (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (v0),
    .out_count (c0),
    .out_frac  (f0),
    .out_zero  (z0)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: scan for the highest set bit, then shift with integer math.
  function automatic logic [17:0] model(input logic v, input logic [7:0] d);
    int lz;
    int cnt1, cnt0, s1, s0;
    lz = 8;
    for (int i = 0; i < 8; i++) if (d[i]) lz = 7 - i;
    cnt1 = lz + 1;
    cnt0 = lz;
    s1 = (int'(d) << cnt1) % 256;
    s0 = (int'(d) << cnt0) % 256;
    return {v, (d == 8'h00), 4'(cnt1), 4'(s1 / 16), 4'(cnt0), 4'(s0 / 16)};
  endfunction

  // Driver: present one input, then check the registered result after the edge.
  task automatic step(input logic v, input logic [7:0] d);
    logic [17:0] e;
    in_valid = v;
    in_data  = d;
    exp_q.push_back(model(v, d));
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("valid",  32'(v1), 32'(e[17]));
    check("valid0", 32'(v0), 32'(e[17]));
    check("zero",   32'(z1), 32'(e[16]));
    check("zero0",  32'(z0), 32'(e[16]));
    check("count1", 32'(c1), 32'(e[15:12]));
    check("frac1",  32'(f1), 32'(e[11:8]));
    check("count0", 32'(c0), 32'(e[7:4]));
    check("frac0",  32'(f0), 32'(e[3:0]));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(v1), 32'd0);
    check({tag, "_count"}, 32'(c1), 32'd0);
    check({tag, "_frac"},  32'(f1), 32'd0);
    check({tag, "_zero"},  32'(z1), 32'd0);
    check({tag, "_valid0"}, 32'(v0), 32'd0);
    check({tag, "_count0"}, 32'(c0), 32'd0);
  endtask

  // Directed vectors with hand-derived results for ADD_OFFSET=1:
  // {data, count, frac, zero}
  logic [16:0] dir_tab [6] = '{
    {8'h80, 4'd1, 4'h0, 1'b0},
    {8'h2C, 4'd3, 4'h6, 1'b0},
    {8'h01, 4'd8, 4'h0, 1'b0},
    {8'hFF, 4'd1, 4'hF, 1'b0},
    {8'h2C, 4'd3, 4'h6, 1'b0},
    {8'h00, 4'd9, 4'h0, 1'b1}
  };

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    check_cleared("reset_async");
    repeat (2) @(posedge clock);
    #1;
    check_cleared("reset_held");
    @(negedge clock);
    reset = 1'b0;

    // Directed, back-to-back on consecutive cycles
    foreach (dir_tab[i]) begin
      logic [16:0] row;
      row      = dir_tab[i];
      in_valid = 1'b1;
      in_data  = row[16:9];
      @(posedge clock);
      #1;
      check("dir_valid", 32'(v1), 32'd1);
      check("dir_count", 32'(c1), 32'(row[8:5]));
      check("dir_frac",  32'(f1), 32'(row[4:1]));
      check("dir_zero",  32'(z1), 32'(row[0]));
    end

    // Mid-stream reset pulsed between edges while out_valid is high
    step(1'b1, 8'hFF);
    #2;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_cleared("reset_mid");
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_reset_idle_valid", 32'(v1), 32'd0);
    step(1'b0, 8'h00);
    step(1'b1, 8'h2C);

    // Exhaustive sweep, both offsets
    for (int d = 0; d < 256; d++) step(1'b1, 8'(d));

    // Random stream with random valid gaps
    for (int n = 0; n < 200; n++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
